dmem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port, 64-word data memory between the pipeline's MEM stage (core port) and a DMA/loader port with a valid/ready handshake. The core port has priority and keeps its same-cycle (asynchronous-read) timing. The DMA port gets registered responses one cycle after acceptance. An optional starvation guard forces a DMA grant after a bounded wait, stalling the core for that one cycle. It sits between the MEM stage, the DMA engine and the data memory.

---
 rtl/dmem_pkg.sv | 31 +++
 rtl/dmem_arbiter_if.sv | 53 +++++
 rtl/dmem_arb_starve_cnt.sv | 37 +++
 rtl/dmem_arbiter.sv | 106 ++++++++++
 tb/tb_dmem_arbiter.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
//==============================================================================
// Module   : dmem_pkg
// Purpose  : Shared types and helpers for the data-memory arbiter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package dmem_pkg;

    localparam int DMEM_DEPTH_WORDS = 64;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CORE = 2'd1,
        GNT_DMA  = 2'd2
    } grant_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_req_t;

    // A DMA address is unusable if misaligned or beyond the last word.
    function automatic logic addr_is_bad(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
//==============================================================================
// Module   : dmem_arbiter_if
// Purpose  : Core, DMA and data-memory signal bundle of the arbiter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface dmem_arbiter_if;

    logic        core_req;
    logic        core_we;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [31:0] core_rdata;
    logic        core_stall;

    logic        dma_valid;
    logic        dma_ready;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_rvalid;
    logic [31:0] dma_rdata;
    logic        dma_err;

    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // Arbiter side.
    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_rdata, core_stall,
        input  dma_valid, dma_we, dma_addr, dma_wdata,
        output dma_ready, dma_rvalid, dma_rdata, dma_err,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Environment side: requesters plus the memory.
    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_rdata, core_stall,
        output dma_valid, dma_we, dma_addr, dma_wdata,
        input  dma_ready, dma_rvalid, dma_rdata, dma_err,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

`default_nettype wire

// File: rtl/dmem_arb_starve_cnt.sv
//==============================================================================
// Module   : dmem_arb_starve_cnt
// Purpose  : Saturating DMA wait counter; raises o_force once the wait limit
//            is reached while the request is still pending.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module dmem_arb_starve_cnt #(
    parameter int MAX_WAIT = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_valid,
    input  wire logic i_ready,
    output logic      o_force
);

    localparam logic [3:0] c_MAX_WAIT = 4'(MAX_WAIT);

    logic [3:0] r_wait_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= 4'd0;
        end else if (!i_valid || i_ready) begin
            r_wait_cnt <= 4'd0;
        end else if (r_wait_cnt != c_MAX_WAIT) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
        end
    end

    assign o_force = i_valid && (r_wait_cnt == c_MAX_WAIT);

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
//==============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares the single-port data memory between the MEM stage (priority,
//            same-cycle access) and a DMA port (registered response). The
//            starvation guard is built only when DMEM_ARB_STARVE_EN is defined.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS,
    parameter int MAX_WAIT    = 4
) (
    input  wire logic     clk,
    input  wire logic     rst,
    dmem_arbiter_if.slave bus
);

    grant_e      w_grant;
    dmem_req_t   w_mem_req;
    logic        w_bad;
    logic        w_force;
    logic        w_dma_ready;
    logic        w_accept;

    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic        r_err;

    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_max_wait_range
        $error("dmem_arbiter: MAX_WAIT must be in 1..15");
    end

`ifdef DMEM_ARB_STARVE_EN
    dmem_arb_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_valid (bus.dma_valid),
        .i_ready (w_dma_ready),
        .o_force (w_force)
    );
`else
    assign w_force = 1'b0;
`endif

    assign w_bad    = addr_is_bad(bus.dma_addr, DEPTH_WORDS);
    assign w_accept = bus.dma_valid && w_dma_ready;

    always_comb begin
        w_grant = GNT_NONE;
        if (!rst) begin
            if (w_force)            w_grant = GNT_DMA;
            else if (bus.core_req)  w_grant = GNT_CORE;
            else if (bus.dma_valid) w_grant = GNT_DMA;
        end
    end

    always_comb begin
        w_mem_req      = '0;
        w_dma_ready    = 1'b0;
        bus.core_stall = 1'b0;
        case (w_grant)
            GNT_CORE: begin
                w_mem_req = '{we: bus.core_we, addr: bus.core_addr, wdata: bus.core_wdata};
            end
            GNT_DMA: begin
                w_mem_req      = '{we: bus.dma_we && !w_bad, addr: bus.dma_addr, wdata: bus.dma_wdata};
                w_dma_ready    = 1'b1;
                bus.core_stall = bus.core_req;
            end
            default: ;
        endcase
    end

    assign bus.mem_we     = w_mem_req.we;
    assign bus.mem_addr   = w_mem_req.addr;
    assign bus.mem_wdata  = w_mem_req.wdata;
    assign bus.core_rdata = bus.mem_rdata;
    assign bus.dma_ready  = w_dma_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid <= 1'b0;
            r_rdata  <= 32'd0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= w_accept;
            if (w_accept) begin
                r_rdata <= (!bus.dma_we && !w_bad) ? bus.mem_rdata : 32'd0;
                r_err   <= w_bad;
            end
        end
    end

    // A reset arriving in the response cycle drops the pending response.
    assign bus.dma_rvalid = r_rvalid && !rst;
    assign bus.dma_rdata  = r_rdata;
    assign bus.dma_err    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
//==============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Self-checking bench for dmem_arbiter against a behavioural model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_dmem_arbiter;

    localparam int DEPTH    = 64;
    localparam int MAX_WAIT = 4;
`ifdef DMEM_ARB_STARVE_EN
    localparam bit STARVE = 1'b1;
`else
    localparam bit STARVE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_arbiter_if bus ();

    dmem_arbiter #(
        .DEPTH_WORDS (DEPTH),
        .MAX_WAIT    (MAX_WAIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Asynchronous-read data memory.
    logic [31:0] tb_mem [DEPTH];
    assign bus.mem_rdata = tb_mem[bus.mem_addr[7:2]];
    always @(posedge clk) if (bus.mem_we) tb_mem[bus.mem_addr[7:2]] <= bus.mem_wdata;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    logic [31:0] ref_mem [DEPTH];
    int          ref_wait = 0;
    bit          pend_v   = 1'b0;
    logic [31:0] pend_d   = '0;
    bit          pend_e   = 1'b0;
    bit          hold     = 1'b0;
    bit          h_dwe;
    logic [31:0] h_daddr, h_dwd;
    bit          last_acc;

    // Outputs captured in the most recent step.
    logic        s_ready, s_stall, s_mem_we, s_rvalid, s_err;
    logic [31:0] s_mem_addr, s_core_rdata, s_dma_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check at the falling edge, advance the model.
    task automatic step(input bit r, input bit creq, input bit cwe,
                        input logic [31:0] caddr, input logic [31:0] cwd,
                        input bit dval, input bit dwe,
                        input logic [31:0] daddr, input logic [31:0] dwd);
        int          g;
        bit          bad, e_we, e_rv;
        logic [31:0] e_addr, e_wd;
        rst            = r;
        bus.core_req   = creq;
        bus.core_we    = cwe;
        bus.core_addr  = caddr;
        bus.core_wdata = cwd;
        bus.dma_valid  = dval;
        bus.dma_we     = dwe;
        bus.dma_addr   = daddr;
        bus.dma_wdata  = dwd;
        @(negedge clk);

        bad = (daddr % 4 != 0) || ((daddr / 4) >= DEPTH);
        // 0 = idle, 1 = core, 2 = dma
        if (r)                                           g = 0;
        else if (STARVE && dval && ref_wait == MAX_WAIT) g = 2;
        else if (creq)                                   g = 1;
        else if (dval)                                   g = 2;
        else                                             g = 0;

        e_we   = (g == 1) ? cwe   : (g == 2) ? (dwe && !bad) : 1'b0;
        e_addr = (g == 1) ? caddr : (g == 2) ? daddr : 32'd0;
        e_wd   = (g == 1) ? cwd   : (g == 2) ? dwd   : 32'd0;
        e_rv   = pend_v && !r;

        chk("dma_ready",  {31'd0, bus.dma_ready},  {31'd0, g == 2});
        chk("core_stall", {31'd0, bus.core_stall}, {31'd0, g == 2 && creq});
        chk("mem_we",     {31'd0, bus.mem_we},     {31'd0, e_we});
        chk("mem_addr",   bus.mem_addr,  e_addr);
        chk("mem_wdata",  bus.mem_wdata, e_wd);
        if (g == 1 && !cwe) chk("core_rdata", bus.core_rdata, ref_mem[caddr[7:2]]);
        chk("dma_rvalid", {31'd0, bus.dma_rvalid}, {31'd0, e_rv});
        if (e_rv) begin
            chk("dma_rdata", bus.dma_rdata, pend_d);
            chk("dma_err",   {31'd0, bus.dma_err}, {31'd0, pend_e});
        end

        s_ready      = bus.dma_ready;
        s_stall      = bus.core_stall;
        s_mem_we     = bus.mem_we;
        s_mem_addr   = bus.mem_addr;
        s_core_rdata = bus.core_rdata;
        s_rvalid     = bus.dma_rvalid;
        s_dma_rdata  = bus.dma_rdata;
        s_err        = bus.dma_err;

        last_acc = (g == 2);
        pend_v   = last_acc;
        if (last_acc) begin
            pend_d = (!dwe && !bad) ? ref_mem[daddr[7:2]] : 32'd0;
            pend_e = bad;
        end
        if (g == 1 && cwe)                ref_mem[caddr[7:2]] = cwd;
        if (last_acc && dwe && !bad)      ref_mem[daddr[7:2]] = dwd;
        if (r || !dval || last_acc)       ref_wait = 0;
        else if (ref_wait < MAX_WAIT)     ref_wait++;
        hold    = dval && !last_acc;
        h_dwe   = dwe;
        h_daddr = daddr;
        h_dwd   = dwd;

        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit r);
        step(r, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    endtask

    initial begin
        int n_dma;
        int n_stall;
        rst = 1'b1;
        bus.core_req = 0; bus.core_we = 0; bus.core_addr = 0; bus.core_wdata = 0;
        bus.dma_valid = 0; bus.dma_we = 0; bus.dma_addr = 0; bus.dma_wdata = 0;
        for (int i = 0; i < DEPTH; i++) begin
            tb_mem[i]  = 32'd0;
            ref_mem[i] = 32'd0;
        end
        @(posedge clk);
        #1;

        // Reset state.
        idle(1);
        idle(1);
        chk("rst_rvalid", {31'd0, s_rvalid}, 32'd0);
        chk("rst_rdata",  s_dma_rdata, 32'd0);
        chk("rst_err",    {31'd0, s_err}, 32'd0);

        // Core write then read back.
        step(0, 1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0);
        chk("cw_mem_we",   {31'd0, s_mem_we}, 32'd1);
        chk("cw_mem_addr", s_mem_addr, 32'h10);
        step(0, 1, 0, 32'h10, 32'h0, 0, 0, 0, 0);
        chk("cr_rdata", s_core_rdata, 32'hDEADBEEF);
        chk("cr_stall", {31'd0, s_stall}, 32'd0);

        // DMA write then read back, back-to-back.
        step(0, 0, 0, 0, 0, 1, 1, 32'h20, 32'h5A5A5A5A);
        chk("dw_ready", {31'd0, s_ready}, 32'd1);
        step(0, 0, 0, 0, 0, 1, 0, 32'h20, 32'h0);
        chk("dw_rvalid", {31'd0, s_rvalid}, 32'd1);
        chk("dw_err",    {31'd0, s_err}, 32'd0);
        idle(0);
        chk("dr_rvalid", {31'd0, s_rvalid}, 32'd1);
        chk("dr_rdata",  s_dma_rdata, 32'h5A5A5A5A);

        // Out-of-range and misaligned DMA accesses.
        step(0, 0, 0, 0, 0, 1, 1, 32'h100, 32'h1234);
        chk("oor_ready",  {31'd0, s_ready}, 32'd1);
        chk("oor_mem_we", {31'd0, s_mem_we}, 32'd0);
        step(0, 0, 0, 0, 0, 1, 0, 32'h22, 32'h0);
        chk("oor_err", {31'd0, s_err}, 32'd1);
        idle(0);
        chk("mis_rvalid", {31'd0, s_rvalid}, 32'd1);
        chk("mis_err",    {31'd0, s_err}, 32'd1);
        chk("mis_rdata",  s_dma_rdata, 32'd0);

        // Reset in the response cycle drops the response.
        step(0, 0, 0, 0, 0, 1, 0, 32'h20, 32'h0);
        idle(1);
        chk("rmid_rvalid", {31'd0, s_rvalid}, 32'd0);
        step(0, 0, 0, 0, 0, 1, 0, 32'h20, 32'h0);
        idle(0);
        chk("rpost_rvalid", {31'd0, s_rvalid}, 32'd1);
        chk("rpost_rdata",  s_dma_rdata, 32'h5A5A5A5A);

        // Sustained contention: core and DMA both requesting for 20 cycles.
        n_dma   = 0;
        n_stall = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 0, 32'h10, 32'h0, 1, 0, 32'h24, 32'h0);
            n_dma   += int'(s_ready);
            n_stall += int'(s_stall);
        end
        chk("contend_dma_grants", n_dma,   STARVE ? 32'd4 : 32'd0);
        chk("contend_stalls",     n_stall, STARVE ? 32'd4 : 32'd0);
        idle(0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            bit          r, creq, cwe, dval, dwe;
            logic [31:0] caddr, cwd, daddr, dwd;
            int          kind;
            r     = ($urandom_range(0, 63) == 0);
            creq  = $urandom_range(0, 1) == 1;
            cwe   = $urandom_range(0, 1) == 1;
            caddr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            cwd   = $urandom;
            if (hold) begin
                dval  = 1'b1;
                dwe   = h_dwe;
                daddr = h_daddr;
                dwd   = h_dwd;
            end else begin
                dval = $urandom_range(0, 1) == 1;
                dwe  = $urandom_range(0, 1) == 1;
                dwd  = $urandom;
                kind = $urandom_range(0, 7);
                if (kind == 0)
                    daddr = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
                else if (kind == 1)
                    daddr = 32'($urandom_range(64, 300)) << 2;
                else
                    daddr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            end
            step(r, creq, cwe, caddr, cwd, dval, dwe, daddr, dwd);
        end
        idle(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
